// File: rtl/wt_wbuf_coalesce_if.sv
// Store, memory-port and load-check signals of the coalescing write buffer.
// The slave modport is the buffer; the master modport is its environment.
interface wt_wbuf_coalesce_if #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              st_valid_i;
  logic              st_ready_o;
  logic [ADDR_W-1:0] st_addr_i;
  logic [DATA_W-1:0] st_data_i;
  logic [BE_W-1:0]   st_be_i;

  logic              mem_req_o;
  logic              mem_gnt_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [BE_W-1:0]   mem_be_o;
  logic              mem_ack_i;

  logic [ADDR_W-1:0] ld_addr_i;
  logic [BE_W-1:0]   ld_be_i;
  logic              ld_hit_o;

  logic [CNT_W-1:0]  count_o;
  logic              empty_o;

  modport slave (
    input  st_valid_i, st_addr_i, st_data_i, st_be_i,
    input  mem_gnt_i, mem_ack_i, ld_addr_i, ld_be_i,
    output st_ready_o, mem_req_o, mem_addr_o, mem_data_o, mem_be_o,
    output ld_hit_o, count_o, empty_o
  );

  modport master (
    output st_valid_i, st_addr_i, st_data_i, st_be_i,
    output mem_gnt_i, mem_ack_i, ld_addr_i, ld_be_i,
    input  st_ready_o, mem_req_o, mem_addr_o, mem_data_o, mem_be_o,
    input  ld_hit_o, count_o, empty_o
  );
endinterface

// File: rtl/wt_wbuf_coalesce.sv
// Write-through store buffer: in-order FIFO of word entries, bytewise merge into
// the youngest entry, bounded outstanding writes and load/store overlap detection.
module wt_wbuf_coalesce #(
  parameter int DEPTH   = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  wt_wbuf_coalesce_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF   = $clog2(BE_W);
  localparam int WA_W  = ADDR_W - OFF;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(BE_W - 1);

  logic [WA_W-1:0]   waddr_reg [DEPTH];
  logic [DATA_W-1:0] data_reg  [DEPTH];
  logic [BE_W-1:0]   be_reg    [DEPTH];
  logic [DEPTH-1:0]  valid_reg;
  logic [PTR_W-1:0]  head_reg, tail_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [OUT_W-1:0]  out_reg;

  logic [PTR_W-1:0]  young_ptr, head_next, tail_next;
  logic [ADDR_W-1:0] st_aligned, ld_aligned;
  logic [DATA_W-1:0] merge_data;
  logic [BE_W-1:0]   merge_be;
  logic [DEPTH-1:0]  hit_vec;
  logic              has_entries, full, mem_req, pop, ack_eff;
  logic              merge_ok, do_merge, do_alloc;

  assign young_ptr = (tail_reg == '0) ? PTR_W'(DEPTH - 1) : tail_reg - PTR_W'(1);
  assign head_next = (head_reg == PTR_W'(DEPTH - 1)) ? '0 : head_reg + PTR_W'(1);
  assign tail_next = (tail_reg == PTR_W'(DEPTH - 1)) ? '0 : tail_reg + PTR_W'(1);

  assign st_aligned  = bus.st_addr_i & WORD_MASK;
  assign ld_aligned  = bus.ld_addr_i & WORD_MASK;
  assign has_entries = (count_reg != '0);
  assign full        = (count_reg == CNT_W'(DEPTH));
  assign mem_req     = has_entries && (out_reg < OUT_W'(MAX_OUT));
  assign pop         = mem_req && bus.mem_gnt_i;
  assign ack_eff     = bus.mem_ack_i && (out_reg != '0);

  // The head being handed to memory this edge is frozen, so a matching store
  // must allocate behind it rather than modify data memory has already sampled.
  assign merge_ok = bus.st_valid_i && has_entries
                 && ({waddr_reg[young_ptr], {OFF{1'b0}}} == st_aligned)
                 && !((young_ptr == head_reg) && pop);
  assign do_merge = merge_ok && (bus.st_be_i != '0);
  assign do_alloc = bus.st_valid_i && !merge_ok && !full && (bus.st_be_i != '0);

  assign bus.st_ready_o = merge_ok || !full || (bus.st_valid_i && (bus.st_be_i == '0));

  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
    assign merge_data[gi*8 +: 8] = bus.st_be_i[gi] ? bus.st_data_i[gi*8 +: 8]
                                                   : data_reg[young_ptr][gi*8 +: 8];
  end
  assign merge_be = be_reg[young_ptr] | bus.st_be_i;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    assign hit_vec[gi] = valid_reg[gi]
                      && ({waddr_reg[gi], {OFF{1'b0}}} == ld_aligned)
                      && ((be_reg[gi] & bus.ld_be_i) != '0);
  end

  assign bus.ld_hit_o   = |hit_vec;
  assign bus.mem_req_o  = mem_req;
  assign bus.mem_addr_o = {waddr_reg[head_reg], {OFF{1'b0}}};
  assign bus.mem_data_o = data_reg[head_reg];
  assign bus.mem_be_o   = be_reg[head_reg];
  assign bus.count_o    = count_reg;
  assign bus.empty_o    = !has_entries && (out_reg == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        waddr_reg[i] <= '0;
        data_reg[i]  <= '0;
        be_reg[i]    <= '0;
      end
      valid_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      out_reg   <= '0;
    end else begin
      if (do_alloc) begin
        waddr_reg[tail_reg] <= st_aligned[ADDR_W-1:OFF];
        data_reg[tail_reg]  <= bus.st_data_i;
        be_reg[tail_reg]    <= bus.st_be_i;
        valid_reg[tail_reg] <= 1'b1;
        tail_reg            <= tail_next;
      end
      if (do_merge) begin
        data_reg[young_ptr] <= merge_data;
        be_reg[young_ptr]   <= merge_be;
      end
      if (pop) begin
        valid_reg[head_reg] <= 1'b0;
        head_reg            <= head_next;
      end
      if (do_alloc && !pop)
        count_reg <= count_reg + CNT_W'(1);
      else if (!do_alloc && pop)
        count_reg <= count_reg - CNT_W'(1);
      if (pop && !ack_eff)
        out_reg <= out_reg + OUT_W'(1);
      else if (!pop && ack_eff)
        out_reg <= out_reg - OUT_W'(1);
    end
  end

  ack_without_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus.mem_ack_i && (out_reg == '0)));
endmodule

// File: tb/tb_wt_wbuf_coalesce.sv
// Directed bench for wt_wbuf_coalesce (DEPTH=2, MAX_OUT=2): merge, backpressure,
// ordering, head-grant exclusion, outstanding limit, load hazard and reset.
module tb_wt_wbuf_coalesce;
  localparam int DEPTH = 2, ADDR_W = 32, DATA_W = 32, MAX_OUT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wt_wbuf_coalesce_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  wt_wbuf_coalesce #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int n_gnt = 0;
  int n_ack = 0;
  bit auto_ack = 1'b0;
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];
  logic [3:0]  wr_be   [$];

  // Memory-side log: one line per accepted write
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.mem_req_o && bus.mem_gnt_i) begin
        wr_addr.push_back(bus.mem_addr_o);
        wr_data.push_back(bus.mem_data_o);
        wr_be.push_back(bus.mem_be_o);
        n_gnt++;
        $display("mem write addr=%08h data=%08h be=%04b", bus.mem_addr_o, bus.mem_data_o, bus.mem_be_o);
      end
      if (bus.mem_ack_i) n_ack++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (auto_ack) bus.mem_ack_i = (n_gnt > n_ack);
  endtask

  task automatic present(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.st_valid_i = 1'b1;
    bus.st_addr_i  = a;
    bus.st_data_i  = d;
    bus.st_be_i    = be;
  endtask

  task automatic release_st();
    bus.st_valid_i = 1'b0;
    bus.st_be_i    = '0;
  endtask

  task automatic store(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic exp_rdy);
    present(a, d, be);
    #1;
    check(tag, bus.st_ready_o, exp_rdy);
    tick();
    release_st();
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (!bus.empty_o && n < 40) begin
      tick();
      n++;
    end
    check(tag, bus.empty_o, 1'b1);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_be.delete();
  endtask

  task automatic stop_mem();
    bus.mem_gnt_i = 1'b0;
    auto_ack      = 1'b0;
    bus.mem_ack_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.st_valid_i = 1'b0;
    bus.st_addr_i  = '0;
    bus.st_data_i  = '0;
    bus.st_be_i    = '0;
    bus.mem_gnt_i  = 1'b0;
    bus.mem_ack_i  = 1'b0;
    bus.ld_addr_i  = '0;
    bus.ld_be_i    = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_req",   bus.mem_req_o,  1'b0);
    check("rst_addr",  bus.mem_addr_o, 32'h0);
    check("rst_data",  bus.mem_data_o, 32'h0);
    check("rst_be",    bus.mem_be_o,   4'h0);
    check("rst_hit",   bus.ld_hit_o,   1'b0);
    check("rst_count", bus.count_o,    2'd0);
    check("rst_empty", bus.empty_o,    1'b1);
    check("rst_ready", bus.st_ready_o, 1'b1);

    // Merge of two half-word stores into one entry
    clear_log();
    present(32'h1000, 32'h0000_BBAA, 4'b0011);
    #1;
    check("t1_ready0", bus.st_ready_o, 1'b1);
    check("t1_nobypass", bus.mem_req_o, 1'b0);
    tick();
    release_st();
    check("t1_req", bus.mem_req_o, 1'b1);
    check("t1_count0", bus.count_o, 2'd1);
    store("t1_ready1", 32'h1002, 32'hDDCC_0000, 4'b1100, 1'b1);
    check("t1_count1", bus.count_o, 2'd1);
    check("t1_data", bus.mem_data_o, 32'hDDCC_BBAA);
    check("t1_be", bus.mem_be_o, 4'hF);
    check("t1_addr", bus.mem_addr_o, 32'h1000);
    bus.mem_gnt_i = 1'b1;
    tick();
    bus.mem_gnt_i = 1'b0;
    check("t1_count_post", bus.count_o, 2'd0);
    check("t1_empty_out", bus.empty_o, 1'b0);
    bus.mem_ack_i = 1'b1;
    tick();
    bus.mem_ack_i = 1'b0;
    check("t1_empty_ack", bus.empty_o, 1'b1);
    tick();
    tick();
    check("t1_nwr", wr_addr.size(), 1);
    check("t1_wr_data", wr_data[0], 32'hDDCC_BBAA);
    check("t1_wr_be", wr_be[0], 4'hF);

    // Full buffer backpressure, youngest merge while full, zero-byte store
    clear_log();
    store("t2_s0", 32'h1000, 32'h1111_1111, 4'hF, 1'b1);
    store("t2_s1", 32'h2000, 32'h2222_2222, 4'hF, 1'b1);
    check("t2_count_full", bus.count_o, 2'd2);
    present(32'h3000, 32'h3333_3333, 4'hF);
    #1;
    check("t2_full_rdy", bus.st_ready_o, 1'b0);
    tick();
    release_st();
    check("t2_count_hold", bus.count_o, 2'd2);
    store("t2_be0_rdy", 32'h9000, 32'hFFFF_FFFF, 4'h0, 1'b1);
    check("t2_be0_count", bus.count_o, 2'd2);
    store("t2_merge_rdy", 32'h2000, 32'h0000_00EE, 4'b0001, 1'b1);
    check("t2_merge_count", bus.count_o, 2'd2);
    bus.mem_gnt_i = 1'b1;
    present(32'h3000, 32'h3333_3333, 4'hF);
    #1;
    check("t2_rdy_gnt", bus.st_ready_o, 1'b0);
    tick();
    release_st();
    bus.mem_gnt_i = 1'b0;
    check("t2_count_pop", bus.count_o, 2'd1);
    store("t2_s3", 32'h3000, 32'h3333_3333, 4'hF, 1'b1);
    check("t2_count_s3", bus.count_o, 2'd2);
    bus.mem_gnt_i = 1'b1;
    auto_ack = 1'b1;
    wait_empty("t2_drain");
    stop_mem();
    check("t2_nwr", wr_addr.size(), 3);
    check("t2_a0", wr_addr[0], 32'h1000);
    check("t2_a1", wr_addr[1], 32'h2000);
    check("t2_d1", wr_data[1], 32'h2222_22EE);
    check("t2_a2", wr_addr[2], 32'h3000);

    // A match against an older entry must not merge
    clear_log();
    store("t3_s0", 32'h1000, 32'hA1A1_A1A1, 4'hF, 1'b1);
    store("t3_s1", 32'h2000, 32'hB2B2_B2B2, 4'hF, 1'b1);
    present(32'h1000, 32'hC3C3_C3C3, 4'hF);
    #1;
    check("t3_old_rdy", bus.st_ready_o, 1'b0);
    bus.mem_gnt_i = 1'b1;
    auto_ack = 1'b1;
    tick();
    #1;
    check("t3_rdy_after_pop", bus.st_ready_o, 1'b1);
    tick();
    release_st();
    wait_empty("t3_drain");
    stop_mem();
    check("t3_nwr", wr_addr.size(), 3);
    check("t3_a0", wr_addr[0], 32'h1000);
    check("t3_d0", wr_data[0], 32'hA1A1_A1A1);
    check("t3_a1", wr_addr[1], 32'h2000);
    check("t3_a2", wr_addr[2], 32'h1000);
    check("t3_d2", wr_data[2], 32'hC3C3_C3C3);

    // Store to the head in its grant cycle allocates a fresh entry
    clear_log();
    store("t4_s0", 32'h4000, 32'h4444_4444, 4'hF, 1'b1);
    bus.mem_gnt_i = 1'b1;
    auto_ack = 1'b1;
    store("t4_rdy", 32'h4000, 32'h0000_0055, 4'b0001, 1'b1);
    check("t4_count", bus.count_o, 2'd1);
    check("t4_head_data", bus.mem_data_o, 32'h0000_0055);
    check("t4_head_be", bus.mem_be_o, 4'b0001);
    wait_empty("t4_drain");
    stop_mem();
    check("t4_nwr", wr_addr.size(), 2);
    check("t4_d0", wr_data[0], 32'h4444_4444);
    check("t4_d1", wr_data[1], 32'h0000_0055);

    // Outstanding limit of two granted writes
    clear_log();
    store("t5_s0", 32'h6000, 32'h6666_6666, 4'hF, 1'b1);
    store("t5_s1", 32'h7000, 32'h7777_7777, 4'hF, 1'b1);
    bus.mem_gnt_i = 1'b1;
    tick();
    store("t5_s2", 32'h8000, 32'h8888_8888, 4'hF, 1'b1);
    check("t5_req_limit", bus.mem_req_o, 1'b0);
    check("t5_count", bus.count_o, 2'd1);
    tick();
    check("t5_req_still", bus.mem_req_o, 1'b0);
    check("t5_nwr2", wr_addr.size(), 2);
    bus.mem_ack_i = 1'b1;
    #1;
    check("t5_req_ack_cycle", bus.mem_req_o, 1'b0);
    tick();
    bus.mem_ack_i = 1'b0;
    check("t5_req_reen", bus.mem_req_o, 1'b1);
    tick();
    check("t5_req_out2", bus.mem_req_o, 1'b0);
    check("t5_count0", bus.count_o, 2'd0);
    check("t5_empty_out2", bus.empty_o, 1'b0);
    bus.mem_ack_i = 1'b1;
    tick();
    check("t5_empty_out1", bus.empty_o, 1'b0);
    tick();
    bus.mem_ack_i = 1'b0;
    check("t5_empty_final", bus.empty_o, 1'b1);
    bus.mem_gnt_i = 1'b0;
    check("t5_nwr3", wr_addr.size(), 3);
    check("t5_a2", wr_addr[2], 32'h8000);

    // Load overlap detection, then reset mid-operation
    store("t6_s0", 32'h5000, 32'h0000_00AB, 4'b0001, 1'b1);
    bus.ld_addr_i = 32'h5000;
    bus.ld_be_i   = 4'b0010;
    #1;
    check("t6_hit_other_byte", bus.ld_hit_o, 1'b0);
    bus.ld_be_i = 4'b0001;
    #1;
    check("t6_hit_same_byte", bus.ld_hit_o, 1'b1);
    bus.ld_addr_i = 32'h5003;
    #1;
    check("t6_hit_unaligned", bus.ld_hit_o, 1'b1);
    bus.ld_addr_i = 32'h6000;
    #1;
    check("t6_hit_other_word", bus.ld_hit_o, 1'b0);
    bus.ld_addr_i = 32'h5000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t6_rst_count", bus.count_o, 2'd0);
    check("t6_rst_empty", bus.empty_o, 1'b1);
    check("t6_rst_hit", bus.ld_hit_o, 1'b0);
    check("t6_rst_req", bus.mem_req_o, 1'b0);
    check("t6_rst_ready", bus.st_ready_o, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wt_wbuf_coalesce.md
# wt_wbuf_coalesce

Parametrised write buffer for the write-through data cache. It sits between the store unit and the cache memory port. Stores queue in a FIFO of word-aligned entries. A new store merges bytewise into the youngest entry when the word addresses match, which generalises the fixed 2-entry buffer to any depth. Entries drain in order under a bound on outstanding writes, and the block reports load/store byte overlap to the load unit.

## Interface
- DEPTH, 2, number of buffer entries (>=1)
- ADDR_W, 32, byte address width
- DATA_W, 32, data width in bits (power of two, >=16); BE_W = DATA_W/8, OFF = log2(BE_W)
- MAX_OUT, 7, maximum granted-but-unacknowledged writes (>=1)

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous reset, active-high
- st_valid_i  in  1  store request
- st_ready_o  out  1  store accepted this cycle when high with st_valid_i
- st_addr_i  in  ADDR_W  byte address; low OFF bits ignored
- st_data_i  in  DATA_W  store data, word-lane aligned
- st_be_i  in  BE_W  byte enables
- mem_req_o  out  1  head entry offered to memory
- mem_gnt_i  in  1  memory accepts head entry
- mem_addr_o  out  ADDR_W  head word address, low OFF bits zero
- mem_data_o  out  DATA_W  head data
- mem_be_o  out  BE_W  head byte enables
- mem_ack_i  in  1  one previously granted write completed
- ld_addr_i  in  ADDR_W  load address under check
- ld_be_i  in  BE_W  load byte enables
- ld_hit_o  out  1  buffered store overlaps load bytes
- count_o  out  log2(DEPTH)+1  valid entries
- empty_o  out  1  no entries and no outstanding writes (fence/flush ready)

## Operation
- Entry fields: valid, word address (ADDR_W-OFF bits), data, be. The FIFO uses head/tail pointers that wrap modulo DEPTH, plus an entry counter.
- Merge condition: st_valid_i, count>0, youngest entry (tail-1) word address equals st_addr_i word address, and NOT (youngest is head AND mem_req_o AND mem_gnt_i this cycle).
- On merge: for each byte i with st_be_i[i]=1, data byte i takes the new value and be[i] is set. Other bytes are unchanged. Count is unchanged.
- Only the youngest entry may merge. A match against an older entry allocates a new entry, which preserves store order.
- Allocate: st_valid_i, no merge, count<DEPTH. The entry is written at tail and the tail advances.
- st_ready_o = merge_condition OR (count<DEPTH). It is computed from registered state plus store inputs and never depends on mem_gnt_i freeing a slot in the same cycle. The one exception is the head-grant exclusion above.
- st_be_i == 0 with st_valid_i: accepted (st_ready_o=1), no state change.
- Drain: mem_req_o = (count>0) AND (outstanding<MAX_OUT). mem_addr/data/be_o show the head entry. On mem_req_o AND mem_gnt_i the head pops and outstanding increments.
- Outstanding counter, width log2(MAX_OUT+1): +1 on grant, -1 on mem_ack_i, unchanged when both occur together. mem_ack_i at outstanding==0 is ignored (assertion fires in simulation).
- Simultaneous allocate and pop: both take effect, and count is unchanged.
- ld_hit_o is combinational: OR over valid entries of (word address match AND |(be & ld_be_i)). It includes the head being granted this cycle. It excludes writes already granted.
- empty_o = (count==0) AND (outstanding==0).
- Reset, mid-operation: all entries are invalidated and pointers, count and outstanding clear. Pending acks arriving after reset are ignored.

## Timing
- Reset values: mem_req_o=0, mem_addr_o/data_o/be_o=0, ld_hit_o=0, count_o=0, empty_o=1, st_ready_o=1.
- Store-to-memory latency: an entry accepted at edge N gives mem_req_o high in cycle N+1 at the earliest. There is no same-cycle bypass.
- A merge into the head during cycle N is visible on mem_data_o/mem_be_o from cycle N+1.
- mem_req_o and the head fields stay stable until grant while mem_req_o is high. A merge can change them only in cycles with no grant. Memory treats data as sampled at the grant edge.
- Full throughput: one store accepted and one entry drained per cycle.
- ld_hit_o and st_ready_o have zero-cycle input-to-output paths. count_o and empty_o are registered-state decodes.

## Test plan
- Merge: DEPTH=2, mem_gnt_i=0. Store 0x1000 be=0011 data=0x0000_BBAA, then 0x1002 be=1100 data=0xDDCC_0000. Required: count_o=1, head data=0xDDCC_BBAA, be=1111. Then mem_gnt_i=1 gives exactly one write.
- Full/backpressure: 3 stores to 0x1000, 0x2000, 0x3000 with gnt held 0. Required: third store sees st_ready_o=0. A fourth store to 0x2000 (youngest) merges with st_ready_o=1. After one grant the store to 0x3000 is accepted.
- Order preservation: stores 0x1000, 0x2000, 0x1000. Required: three entries, memory sees 0x1000, 0x2000, 0x1000 in that order.
- Grant-exclusion: one entry at 0x4000 granted in the same cycle as a store to 0x4000. Required: no merge, new entry allocated, two memory writes.
- Outstanding limit: MAX_OUT=2, gnt=1, no acks. Required: mem_req_o drops after 2 grants. One mem_ack_i re-enables it the next cycle. empty_o goes to 1 only after the final ack.
- Load hazard and reset: entry 0x5000 be=0001. Load 0x5000 be=0010 gives ld_hit_o=0, be=0001 gives ld_hit_o=1. Assert rst_i one cycle: count_o=0, empty_o=1, ld_hit_o=0, mem_req_o=0.
